// File: rtl/para_defines.sv
// Shared AXI-lite master definitions: state encoding, response codes,
// default timeout and the macro widths used across the bus interface.
`ifndef ysyx_23060124_ISA_WIDTH
`define ysyx_23060124_ISA_WIDTH 32
`endif
`ifndef ysyx_23060124_ISA_ADDR_WIDTH
`define ysyx_23060124_ISA_ADDR_WIDTH 32
`endif
`ifndef ysyx_23060124_OPT_WIDTH
`define ysyx_23060124_OPT_WIDTH 4
`endif

package para_defines;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_ADDR = 3'd1,
        S_RD_DATA = 3'd2,
        S_WR_REQ  = 3'd3,
        S_WR_RESP = 3'd4,
        S_RSP     = 3'd5
    } axi_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int unsigned TIMEOUT_DEFAULT = 255;

    // OKAY and EXOKAY are both treated as success
    function automatic logic resp_is_err(input logic [1:0] resp);
        logic err;
        unique case (resp)
            RESP_OKAY, RESP_EXOKAY:   err = 1'b0;
            RESP_SLVERR, RESP_DECERR: err = 1'b1;
            default:                  err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/axi_lite_timeout.sv
// Saturating wait-cycle counter; expired flags the last allowed
// cycle of a bus-wait state.
module axi_lite_timeout
    import para_defines::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] MAX  = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear)
            cnt_d = '0;
        else if (enable && cnt_q != MAX)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    // cnt_q counts cycles already spent, so LAST marks the Nth cycle
    assign expired = enable && (cnt_q >= LAST);

endmodule

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-lite master bridging a core request/response
// port to the AXI read and write channels, with a bus-wait timeout.
`ifndef ysyx_23060124_ISA_WIDTH
`define ysyx_23060124_ISA_WIDTH 32
`endif
`ifndef ysyx_23060124_ISA_ADDR_WIDTH
`define ysyx_23060124_ISA_ADDR_WIDTH 32
`endif
`ifndef ysyx_23060124_OPT_WIDTH
`define ysyx_23060124_OPT_WIDTH 4
`endif

module axi_lite_master
    import para_defines::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic                                     M_AXI_ACLK,
    input  logic                                     M_AXI_ARESET,
    input  logic                                     req_valid,
    output logic                                     req_ready,
    input  logic                                     req_wen,
    input  logic [`ysyx_23060124_ISA_ADDR_WIDTH-1:0] req_addr,
    input  logic [`ysyx_23060124_ISA_WIDTH-1:0]      req_wdata,
    input  logic [`ysyx_23060124_OPT_WIDTH-1:0]      req_opt,
    output logic                                     rsp_valid,
    input  logic                                     rsp_ready,
    output logic [`ysyx_23060124_ISA_WIDTH-1:0]      rsp_rdata,
    output logic                                     rsp_err,
    output logic [`ysyx_23060124_ISA_ADDR_WIDTH-1:0] M_AXI_ARADDR,
    output logic                                     M_AXI_ARVALID,
    input  logic                                     M_AXI_ARREADY,
    input  logic [`ysyx_23060124_ISA_WIDTH-1:0]      M_AXI_RDATA,
    input  logic [1:0]                               M_AXI_RRESP,
    input  logic                                     M_AXI_RVALID,
    output logic                                     M_AXI_RREADY,
    output logic [`ysyx_23060124_ISA_ADDR_WIDTH-1:0] M_AXI_AWADDR,
    output logic                                     M_AXI_AWVALID,
    input  logic                                     M_AXI_AWREADY,
    output logic [`ysyx_23060124_ISA_WIDTH-1:0]      M_AXI_WDATA,
    output logic [`ysyx_23060124_OPT_WIDTH-1:0]      M_AXI_WSTRB,
    output logic                                     M_AXI_WVALID,
    input  logic                                     M_AXI_WREADY,
    input  logic [1:0]                               M_AXI_BRESP,
    input  logic                                     M_AXI_BVALID,
    output logic                                     M_AXI_BREADY
);

    axi_state_t state_q, state_d;

    logic [`ysyx_23060124_ISA_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [`ysyx_23060124_ISA_WIDTH-1:0]      wdata_q, wdata_d;
    logic [`ysyx_23060124_OPT_WIDTH-1:0]      opt_q, opt_d;
    logic [`ysyx_23060124_ISA_WIDTH-1:0]      rdata_q, rdata_d;
    logic                                     err_q, err_d;
    logic                                     aw_done_q, aw_done_d;
    logic                                     w_done_q, w_done_d;

    logic in_wait;
    logic expired;
    logic aw_hs;
    logic w_hs;

    assign in_wait = (state_q == S_RD_ADDR) || (state_q == S_RD_DATA) ||
                     (state_q == S_WR_REQ)  || (state_q == S_WR_RESP);

    axi_lite_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (M_AXI_ACLK),
        .rst     (M_AXI_ARESET),
        .clear   (state_d != state_q),
        .enable  (in_wait),
        .expired (expired)
    );

    assign aw_hs = (state_q == S_WR_REQ) && !aw_done_q && M_AXI_AWREADY;
    assign w_hs  = (state_q == S_WR_REQ) && !w_done_q && M_AXI_WREADY;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        opt_d     = opt_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;

        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    addr_d    = req_addr;
                    wdata_d   = req_wdata;
                    opt_d     = req_opt;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = req_wen ? S_WR_REQ : S_RD_ADDR;
                end
            end
            S_RD_ADDR: begin
                if (M_AXI_ARREADY)
                    state_d = S_RD_DATA;
                else if (expired)
                    state_d = S_RSP;
            end
            S_RD_DATA: begin
                if (M_AXI_RVALID) begin
                    rdata_d = M_AXI_RDATA;
                    err_d   = resp_is_err(M_AXI_RRESP);
                    state_d = S_RSP;
                end else if (expired) begin
                    state_d = S_RSP;
                end
            end
            S_WR_REQ: begin
                aw_done_d = aw_done_q || aw_hs;
                w_done_d  = w_done_q || w_hs;
                if (aw_done_d && w_done_d)
                    state_d = S_WR_RESP;
                else if (expired)
                    state_d = S_RSP;
            end
            S_WR_RESP: begin
                if (M_AXI_BVALID) begin
                    rdata_d = '0;
                    err_d   = resp_is_err(M_AXI_BRESP);
                    state_d = S_RSP;
                end else if (expired) begin
                    state_d = S_RSP;
                end
            end
            S_RSP: begin
                if (rsp_ready)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // a wait state left for RSP without its own handshake is a timeout
        if (in_wait && state_d == S_RSP && expired &&
            !(state_q == S_RD_DATA && M_AXI_RVALID) &&
            !(state_q == S_WR_RESP && M_AXI_BVALID)) begin
            rdata_d = '0;
            err_d   = 1'b1;
        end
    end

    always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
        if (M_AXI_ARESET) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            opt_q     <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            opt_q     <= opt_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    assign req_ready     = (state_q == S_IDLE) && !M_AXI_ARESET;
    assign rsp_valid     = (state_q == S_RSP);
    assign rsp_rdata     = rdata_q;
    assign rsp_err       = err_q;

    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_ARVALID = (state_q == S_RD_ADDR);
    assign M_AXI_RREADY  = (state_q == S_RD_DATA);
    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_AWVALID = (state_q == S_WR_REQ) && !aw_done_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = opt_q;
    assign M_AXI_WVALID  = (state_q == S_WR_REQ) && !w_done_q;
    assign M_AXI_BREADY  = (state_q == S_WR_RESP);

endmodule

// File: tb/tb_axi_lite_master.sv
// Directed bench for axi_lite_master: read, write, error hold,
// timeout, back-to-back and mid-transaction reset.
`ifndef ysyx_23060124_ISA_WIDTH
`define ysyx_23060124_ISA_WIDTH 32
`endif
`ifndef ysyx_23060124_ISA_ADDR_WIDTH
`define ysyx_23060124_ISA_ADDR_WIDTH 32
`endif
`ifndef ysyx_23060124_OPT_WIDTH
`define ysyx_23060124_OPT_WIDTH 4
`endif

module tb_axi_lite_master;

    logic        clk;
    logic        rst;
    logic        req_valid, req_ready, req_wen;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_opt;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] araddr, rdata, awaddr, wdata;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  rresp, bresp;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic [3:0]  wstrb;

    int vec;
    int err;

    axi_lite_master #(.TIMEOUT_CYCLES(8)) dut (
        .M_AXI_ACLK    (clk),
        .M_AXI_ARESET  (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_wen       (req_wen),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .req_opt       (req_opt),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_rdata     (rsp_rdata),
        .rsp_err       (rsp_err),
        .M_AXI_ARADDR  (araddr),
        .M_AXI_ARVALID (arvalid),
        .M_AXI_ARREADY (arready),
        .M_AXI_RDATA   (rdata),
        .M_AXI_RRESP   (rresp),
        .M_AXI_RVALID  (rvalid),
        .M_AXI_RREADY  (rready),
        .M_AXI_AWADDR  (awaddr),
        .M_AXI_AWVALID (awvalid),
        .M_AXI_AWREADY (awready),
        .M_AXI_WDATA   (wdata),
        .M_AXI_WSTRB   (wstrb),
        .M_AXI_WVALID  (wvalid),
        .M_AXI_WREADY  (wready),
        .M_AXI_BRESP   (bresp),
        .M_AXI_BVALID  (bvalid),
        .M_AXI_BREADY  (bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req_valid = 0; req_wen = 0; req_addr = 0; req_wdata = 0; req_opt = 0;
        rsp_ready = 0; arready = 0; rvalid = 0; rdata = 0; rresp = 0;
        awready = 0; wready = 0; bvalid = 0; bresp = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        clear_inputs();
        repeat (3) step();
        vec++;
        if ({arvalid, rready, awvalid, wvalid, bready, rsp_valid, rsp_err} !== 7'b0) begin
            err++;
            $display("FAIL reset_ctrl: got %b want 0000000",
                     {arvalid, rready, awvalid, wvalid, bready, rsp_valid, rsp_err});
        end
        vec++;
        if (rsp_rdata !== 32'h0 || araddr !== 32'h0) begin
            err++;
            $display("FAIL reset_data: rdata %h araddr %h want 0", rsp_rdata, araddr);
        end
        rst = 0;
        #1;
        vec++;
        if (req_ready !== 1'b1) begin
            err++;
            $display("FAIL reset_ready: got %b want 1", req_ready);
        end
    endtask

    task automatic test_read();
        int lat;
        req_valid = 1; req_wen = 0; req_addr = 32'h8000_0000;
        arready = 1; rvalid = 1; rdata = 32'hDEAD_BEEF; rresp = 2'b01;
        vec++;
        if (req_ready !== 1'b1) begin
            err++;
            $display("FAIL rd_req_ready: got %b want 1", req_ready);
        end
        step();
        req_valid = 0;
        vec++;
        if (arvalid !== 1'b1 || araddr !== 32'h8000_0000) begin
            err++;
            $display("FAIL rd_ar: arvalid %b araddr %h want 1 80000000", arvalid, araddr);
        end
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            step();
            lat++;
        end
        vec++;
        if (lat !== 3) begin
            err++;
            $display("FAIL rd_latency: got %0d want 3", lat);
        end
        vec++;
        if (rsp_rdata !== 32'hDEAD_BEEF || rsp_err !== 1'b0) begin
            err++;
            $display("FAIL rd_data: got %h err %b want deadbeef 0", rsp_rdata, rsp_err);
        end
        clear_inputs();
        rsp_ready = 1;
        step();
        rsp_ready = 0;
        vec++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            err++;
            $display("FAIL rd_idle: ready %b valid %b want 1 0", req_ready, rsp_valid);
        end
    endtask

    task automatic test_write();
        req_valid = 1; req_wen = 1; req_addr = 32'h8000_0010;
        req_wdata = 32'h1234_5678; req_opt = 4'hF;
        step();
        req_valid = 0;
        vec++;
        if ({awvalid, wvalid, req_ready} !== 3'b110) begin
            err++;
            $display("FAIL wr_rise: got %b want 110", {awvalid, wvalid, req_ready});
        end
        vec++;
        if (awaddr !== 32'h8000_0010 || wdata !== 32'h1234_5678 || wstrb !== 4'hF) begin
            err++;
            $display("FAIL wr_bus: got %h %h %h want 80000010 12345678 f", awaddr, wdata, wstrb);
        end
        awready = 1;
        step();
        awready = 0;
        vec++;
        if ({awvalid, wvalid} !== 2'b01) begin
            err++;
            $display("FAIL wr_aw_drop: got %b want 01", {awvalid, wvalid});
        end
        wready = 1;
        step();
        wready = 0;
        vec++;
        if ({awvalid, wvalid, bready} !== 3'b001) begin
            err++;
            $display("FAIL wr_w_drop: got %b want 001", {awvalid, wvalid, bready});
        end
        bvalid = 1; bresp = 2'b00;
        step();
        bvalid = 0;
        vec++;
        if ({bready, rsp_valid, rsp_err} !== 3'b010 || rsp_rdata !== 32'h0) begin
            err++;
            $display("FAIL wr_rsp: got %b rdata %h want 010 0",
                     {bready, rsp_valid, rsp_err}, rsp_rdata);
        end
        rsp_ready = 1;
        step();
        clear_inputs();
    endtask

    task automatic test_read_err_hold();
        int n;
        req_valid = 1; req_wen = 0; req_addr = 32'h8000_0004;
        arready = 1; rvalid = 1; rdata = 32'hCAFE_F00D; rresp = 2'b10;
        step();
        req_valid = 0;
        n = 0;
        while (!rsp_valid && n < 20) begin
            step();
            n++;
        end
        rvalid = 1; rdata = 32'h5555_AAAA; rresp = 2'b00;
        for (int i = 0; i < 4; i++) begin
            vec++;
            if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'hCAFE_F00D) begin
                err++;
                $display("FAIL err_hold[%0d]: valid %b err %b rdata %h want 1 1 cafef00d",
                         i, rsp_valid, rsp_err, rsp_rdata);
            end
            step();
        end
        clear_inputs();
        rsp_ready = 1;
        step();
        rsp_ready = 0;
    endtask

    task automatic test_timeout();
        int n;
        req_valid = 1; req_wen = 0; req_addr = 32'h8000_0020;
        step();
        req_valid = 0;
        n = 0;
        while (arvalid && n < 20) begin
            n++;
            step();
        end
        vec++;
        if (n !== 8) begin
            err++;
            $display("FAIL to_cycles: got %0d want 8", n);
        end
        vec++;
        if ({arvalid, rready, rsp_valid, rsp_err} !== 4'b0011 || rsp_rdata !== 32'h0) begin
            err++;
            $display("FAIL to_rsp: got %b rdata %h want 0011 0",
                     {arvalid, rready, rsp_valid, rsp_err}, rsp_rdata);
        end
        rsp_ready = 1;
        step();
        rsp_ready = 0;
    endtask

    task automatic test_back_to_back();
        int n;
        req_valid = 1; req_wen = 1; req_addr = 32'h8000_0030;
        req_wdata = 32'h0BAD_F00D; req_opt = 4'h3;
        awready = 1; wready = 1; bvalid = 1; bresp = 2'b11;
        step();
        req_valid = 0;
        vec++;
        if ({awvalid, wvalid, wstrb} !== 6'b11_0011) begin
            err++;
            $display("FAIL b2b_wr: got %b want 110011", {awvalid, wvalid, wstrb});
        end
        n = 0;
        while (!rsp_valid && n < 20) begin
            step();
            n++;
        end
        vec++;
        if (rsp_err !== 1'b1 || n !== 2) begin
            err++;
            $display("FAIL b2b_bresp: err %b cycles %0d want 1 2", rsp_err, n);
        end
        clear_inputs();
        rsp_ready = 1;
        step();
        rsp_ready = 0;
        req_valid = 1; req_wen = 0; req_addr = 32'h8000_0040;
        arready = 1; rvalid = 1; rdata = 32'h0000_1111; rresp = 2'b00;
        vec++;
        if (req_ready !== 1'b1) begin
            err++;
            $display("FAIL b2b_ready: got %b want 1", req_ready);
        end
        step();
        req_valid = 0;
        step();
        step();
        vec++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0000_1111 || rsp_err !== 1'b0) begin
            err++;
            $display("FAIL b2b_rd: valid %b rdata %h err %b want 1 00001111 0",
                     rsp_valid, rsp_rdata, rsp_err);
        end
        clear_inputs();
        rsp_ready = 1;
        step();
        rsp_ready = 0;
    endtask

    task automatic test_reset_mid();
        req_valid = 1; req_wen = 1; req_addr = 32'h8000_0050;
        req_wdata = 32'hFFFF_0000; req_opt = 4'hF;
        awready = 1; wready = 1;
        step();
        req_valid = 0;
        step();
        vec++;
        if (bready !== 1'b1) begin
            err++;
            $display("FAIL rm_bready: got %b want 1", bready);
        end
        #2;
        rst = 1;
        #1;
        vec++;
        if ({arvalid, rready, awvalid, wvalid, bready, rsp_valid, rsp_err, req_ready} !== 8'b0) begin
            err++;
            $display("FAIL rm_ctrl: got %b want 00000000",
                     {arvalid, rready, awvalid, wvalid, bready, rsp_valid, rsp_err, req_ready});
        end
        vec++;
        if ({awaddr, wdata, wstrb, rsp_rdata} !== 100'b0) begin
            err++;
            $display("FAIL rm_data: got %h %h %h %h want 0", awaddr, wdata, wstrb, rsp_rdata);
        end
        clear_inputs();
        step();
        rst = 0;
        #1;
        vec++;
        if (req_ready !== 1'b1) begin
            err++;
            $display("FAIL rm_release: got %b want 1", req_ready);
        end
        repeat (3) begin
            step();
            vec++;
            if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
                err++;
                $display("FAIL rm_quiet: valid %b ready %b want 0 1", rsp_valid, req_ready);
            end
        end
    endtask

    initial begin
        vec = 0;
        err = 0;
        test_reset();
        step();
        test_read();
        test_write();
        test_read_err_hold();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule

// File: doc/axi_lite_master.md
AXI_LITE_MASTER -- requirements
Module: axi_lite_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning cycles waited in any bus-wait state before aborting with error.
REQ-002 SHALL have port M_AXI_ACLK  in  1  the single clock; all logic on rising edge.
REQ-003 SHALL have port M_AXI_ARESET  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have req_valid in 1, req_ready out 1, req_wen in 1, req_addr in `ysyx_23060124_ISA_ADDR_WIDTH, req_wdata in `ysyx_23060124_ISA_WIDTH, req_opt in `ysyx_23060124_OPT_WIDTH: the core-side request (req_wen=1 write).
REQ-005 SHALL have rsp_valid out 1, rsp_ready in 1, rsp_rdata out `ysyx_23060124_ISA_WIDTH, rsp_err out 1: the core-side response.
REQ-006 SHALL have M_AXI_ARADDR/ARVALID out, ARREADY in; M_AXI_RDATA/RRESP[1:0]/RVALID in, RREADY out.
REQ-007 SHALL have M_AXI_AWADDR/AWVALID out, AWREADY in; M_AXI_WDATA/WVALID out, WSTRB out `ysyx_23060124_OPT_WIDTH (carries req_opt), WREADY in; M_AXI_BRESP[1:0]/BVALID in, BREADY out.

Function
REQ-008 SHALL implement FSM states IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RSP.
REQ-009 SHALL drive req_ready=1 only in IDLE; handshake req_valid&req_ready latches addr/wdata/opt/wen into registers.
REQ-010 IDLE -> RD_ADDR on accepted read; IDLE -> WR_REQ on accepted write; next-cycle bus valids come from latched registers only.
REQ-011 RD_ADDR: ARVALID=1, ARADDR stable until ARVALID&ARREADY; then -> RD_DATA, ARVALID=0 next cycle.
REQ-012 RD_DATA: RREADY=1; on RVALID latch RDATA into rsp_rdata, rsp_err=RRESP[1]; -> RSP.
REQ-013 WR_REQ: AWVALID and WVALID SHALL rise in the same cycle; each drops the cycle after its own handshake; both done (same or different cycles) -> WR_RESP.
REQ-014 WR_RESP: BREADY=1; on BVALID rsp_err=BRESP[1], rsp_rdata=0; -> RSP.
REQ-015 RRESP/BRESP 2'b00 and 2'b01 SHALL both count as success; 2'b10/2'b11 as error.
REQ-016 RSP: rsp_valid=1, rsp_rdata/rsp_err stable until rsp_ready; then -> IDLE; back-to-back request accepted next cycle earliest.
REQ-017 Timeout counter SHALL clear on each state change and increment each cycle in RD_ADDR, RD_DATA, WR_REQ, WR_RESP; reaching TIMEOUT_CYCLES forces -> RSP with rsp_err=1, rsp_rdata=0, all AXI valids/readies 0 next cycle.
REQ-018 Counter SHALL saturate, never wrap; width = clog2(TIMEOUT_CYCLES+1).
REQ-019 Never more than one outstanding transaction; AXI inputs ignored outside their wait state.
REQ-020 Minimum latency: read req accept to rsp_valid = 3 cycles with zero-wait responder.

Reset
REQ-021 On M_AXI_ARESET=1, asynchronously: state=IDLE, all AXI valid/ready outputs 0, rsp_valid=0, rsp_err=0, rsp_rdata=0, address/data registers 0, counter 0.
REQ-022 Reset mid-transaction SHALL abandon it with no response; req_ready=1 first cycle after release.

Structure
REQ-023 State encoding, RESP codes, TIMEOUT default SHALL live in the shared para_defines package; widths reuse existing ISA/OPT macros.
REQ-024 Timeout counter SHALL be sub-module axi_lite_timeout (clear, enable, expired).

Verification
REQ-025 Read 0x80000000 against zero-wait responder returning 0xDEADBEEF, RRESP=01 -> rsp_rdata=0xDEADBEEF, rsp_err=0, 3 cycles after accept.
REQ-026 Write addr 0x80000010, data 0x12345678, opt=SW; AWREADY 1 cycle before WREADY -> AWVALID drops first, WVALID held, single BREADY handshake, rsp_err=0.
REQ-027 Read with RRESP=2'b10 -> rsp_err=1; rsp_ready held 0 for 4 cycles -> rsp_valid/rsp_rdata stable throughout.
REQ-028 TIMEOUT_CYCLES=8, ARREADY never asserted -> ARVALID drops and rsp_valid=1, rsp_err=1 after 8 cycles in RD_ADDR.
REQ-029 Assert M_AXI_ARESET during WR_RESP -> all outputs 0 immediately, no rsp_valid, req_ready=1 after release.
